// File: rtl/res_seq_ctrl.sv
// Run sequencer for the ESN reservoir: clears feedback, steps the input ROM, gates the PE clock
// and streams post-washout state vectors. Optional continuous mode via RES_SEQ_LOOP_EN.
module res_seq_ctrl #(
   parameter int unsigned ADDR_W      = 6,
   parameter int unsigned NUM_SAMPLES = 64,
   parameter int unsigned WASHOUT     = 8,
   parameter int unsigned STEP_CYC    = 4,
   parameter int unsigned XW          = 128
) (
   input  logic              clk,
   input  logic              rst_N,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              pe_ce,
   output logic              state_clr_N,
   input  logic [XW-1:0]     xstate_in,
   output logic [XW-1:0]     out_data,
   output logic [ADDR_W-1:0] out_idx,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int unsigned PH_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
   localparam logic [PH_W-1:0]   PH_LAST = PH_W'(STEP_CYC - 1);
   localparam logic [ADDR_W-1:0] N_LAST  = ADDR_W'(NUM_SAMPLES - 1);
   localparam logic [ADDR_W-1:0] N_WASH  = ADDR_W'(WASHOUT);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StRun,
      StDrain,
      StDone
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_n, w_n_nxt;
   logic [PH_W-1:0]   r_phase, w_phase_nxt;
   logic              r_busy, r_done, r_clr_n, r_valid;
   logic [XW-1:0]     r_data;
   logic [ADDR_W-1:0] r_idx;

   logic w_last_ph, w_last_n, w_wash_ok, w_cap_due, w_accept, w_stall, w_cap;

`ifdef RES_SEQ_LOOP_EN
   // Washout only discards states on the first pass through the ROM.
   logic r_first, w_first_nxt;
   assign w_wash_ok = (r_n >= N_WASH) || !r_first;
`else
   assign w_wash_ok = (r_n >= N_WASH);
`endif

   assign w_last_ph = (r_phase == PH_LAST);
   assign w_last_n  = (r_n == N_LAST);
   assign w_cap_due = (r_state == StRun) && w_last_ph && w_wash_ok;
   assign w_accept  = r_valid && out_ready;
   // A capture cannot overwrite a beat the consumer has not taken yet.
   assign w_stall   = w_cap_due && r_valid && !out_ready;
   assign w_cap     = w_cap_due && !w_stall && !abort;

   assign pe_ce       = (r_state == StRun) && !w_stall;
   assign busy        = r_busy;
   assign done        = r_done;
   assign rom_addr    = r_n;
   assign state_clr_N = r_clr_n;
   assign out_data    = r_data;
   assign out_idx     = r_idx;
   assign out_valid   = r_valid;

   always_comb begin
      w_state_nxt = r_state;
      w_n_nxt     = r_n;
      w_phase_nxt = r_phase;
`ifdef RES_SEQ_LOOP_EN
      w_first_nxt = r_first;
`endif
      if (abort) begin
         w_state_nxt = StIdle;
      end else begin
         case (r_state)
            StIdle: begin
               if (start) begin
                  w_state_nxt = StClear;
                  w_n_nxt     = '0;
                  w_phase_nxt = '0;
`ifdef RES_SEQ_LOOP_EN
                  w_first_nxt = 1'b1;
`endif
               end
            end
            StClear: begin
               w_state_nxt = StRun;
            end
            StRun: begin
               if (!w_stall) begin
                  if (w_last_ph) begin
                     w_phase_nxt = '0;
                     if (w_last_n) begin
`ifdef RES_SEQ_LOOP_EN
                        w_n_nxt     = '0;
                        w_first_nxt = 1'b0;
`else
                        w_state_nxt = StDrain;
`endif
                     end else begin
                        w_n_nxt = r_n + 1'b1;
                     end
                  end else begin
                     w_phase_nxt = r_phase + 1'b1;
                  end
               end
            end
            StDrain: begin
               if (!r_valid || w_accept) w_state_nxt = StDone;
            end
            StDone: begin
               w_state_nxt = StIdle;
            end
            default: begin
               w_state_nxt = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_N) begin
      if (!rst_N) begin
         r_state <= StIdle;
         r_n     <= '0;
         r_phase <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_clr_n <= 1'b1;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_n     <= w_n_nxt;
         r_phase <= w_phase_nxt;
         r_busy  <= (w_state_nxt == StClear) || (w_state_nxt == StRun) ||
                    (w_state_nxt == StDrain);
         r_done  <= (w_state_nxt == StDone);
         r_clr_n <= (w_state_nxt != StClear);
         // Capture on the accepting edge reloads the beat, keeping valid high.
         if (abort) begin
            r_valid <= 1'b0;
         end else if (w_cap) begin
            r_valid <= 1'b1;
            r_data  <= xstate_in;
            r_idx   <= r_n;
         end else if (w_accept) begin
            r_valid <= 1'b0;
         end
      end
   end

`ifdef RES_SEQ_LOOP_EN
   always_ff @(posedge clk or negedge rst_N) begin
      if (!rst_N) r_first <= 1'b1;
      else        r_first <= w_first_nxt;
   end
`endif

endmodule

// File: tb/tb_res_seq_ctrl.sv
// Bench for res_seq_ctrl: directed timing scenarios plus random backpressure/abort traffic,
// checked every cycle against a sample-progress model.
module tb_res_seq_ctrl;

   localparam int ADDR_W = 6;
   localparam int NUM    = 16;
   localparam int WASH   = 4;
   localparam int STEP   = 4;
   localparam int XW     = 128;

   logic              clk = 1'b0;
   logic              rst_N = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              out_ready = 1'b0;
   logic              busy, done, pe_ce, state_clr_N, out_valid;
   logic [ADDR_W-1:0] rom_addr, out_idx;
   logic [XW-1:0]     xstate_in, out_data;
   logic [31:0]       seed;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int s;
   int n_beats, n_done, done_cyc;

   // Model: mode 0 idle, 1 clear, 2 run, 3 drain, 4 done; m_prog counts unstalled run cycles.
   int m_mode, m_prog, m_idx;
   bit m_vld, m_first;

   always #5 clk = ~clk;

   function automatic logic [XW-1:0] pattern(input logic [ADDR_W-1:0] a, input logic [31:0] sd);
      logic [31:0] w;
      w = sd ^ (32'h9E3779B9 * {26'd0, a});
      return {w, ~w, w ^ 32'h5A5A5A5A, {26'd0, a}};
   endfunction

   // Stand-in for the PE array: state vector is a hash of the sample being processed.
   assign xstate_in = pattern(rom_addr, seed);

   res_seq_ctrl #(
      .ADDR_W(ADDR_W), .NUM_SAMPLES(NUM), .WASHOUT(WASH), .STEP_CYC(STEP), .XW(XW)
   ) dut (
      .clk(clk), .rst_N(rst_N), .start(start), .abort(abort), .busy(busy), .done(done),
      .rom_addr(rom_addr), .pe_ce(pe_ce), .state_clr_N(state_clr_N), .xstate_in(xstate_in),
      .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic bit cap_due();
      int n;
      n = m_prog / STEP;
      return (m_mode == 2) && ((m_prog % STEP) == STEP - 1) && (n >= WASH || !m_first);
   endfunction

   function automatic bit exp_pe(input bit rdy);
      return (m_mode == 2) && !(cap_due() && m_vld && !rdy);
   endfunction

   task automatic model_edge(input bit st, input bit ab, input bit rdy);
      bit acc, cap, lastph;
      int n;
      acc = m_vld && rdy;
      if (ab) begin
         m_mode = 0;
         m_vld  = 0;
      end else begin
         case (m_mode)
            0: if (st) m_mode = 1;
            1: begin
               m_mode  = 2;
               m_prog  = 0;
               m_first = 1;
            end
            2: begin
               n      = m_prog / STEP;
               lastph = (m_prog % STEP) == STEP - 1;
               cap    = cap_due();
               if (!(cap && m_vld && !rdy)) begin
                  if (cap) begin
                     m_vld = 1;
                     m_idx = n;
                  end else if (acc) begin
                     m_vld = 0;
                  end
                  m_prog++;
                  if (lastph && n == NUM - 1) begin
`ifdef RES_SEQ_LOOP_EN
                     m_prog  = 0;
                     m_first = 0;
`else
                     m_mode = 3;
`endif
                  end
               end
            end
            3: begin
               if (!m_vld || acc) m_mode = 4;
               if (acc) m_vld = 0;
            end
            default: m_mode = 0;
         endcase
      end
   endtask

   task automatic check_outputs();
      chk("busy", busy, (m_mode >= 1 && m_mode <= 3));
      chk("done", done, m_mode == 4);
      chk("state_clr_N", state_clr_N, m_mode != 1);
      chk("out_valid", out_valid, m_vld);
      if (m_vld) begin
         chk("out_idx", out_idx, m_idx);
         chk("out_data", out_data, pattern(ADDR_W'(m_idx), seed));
      end
      if (m_mode == 2) chk("rom_addr_run", rom_addr, m_prog / STEP);
      if (m_mode == 1) chk("rom_addr_clear", rom_addr, 0);
   endtask

   // Called at posedge+1: drive inputs, check pe_ce, advance one edge, check registered outputs.
   task automatic cycle(input bit st, input bit ab, input bit rdy);
      start     = st;
      abort     = ab;
      out_ready = rdy;
      #1;
      chk("pe_ce", pe_ce, exp_pe(rdy));
      if (!ab && out_valid && rdy) n_beats++;
      @(posedge clk);
      model_edge(st, ab, rdy);
      cyc++;
      #1;
      check_outputs();
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
   endtask

   task automatic run_until(input int base, input int target, input bit rdy);
      while (cyc < base + target) cycle(0, 0, rdy);
   endtask

   task automatic clear_stats();
      n_beats  = 0;
      n_done   = 0;
      done_cyc = -1;
      s        = cyc;
   endtask

   task automatic check_reset_values();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_pe_ce", pe_ce, 0);
      chk("rst_state_clr_N", state_clr_N, 1);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_valid", out_valid, 0);
   endtask

   // Asserts reset mid-cycle and checks outputs before any clock edge arrives.
   task automatic do_reset();
      start     = 0;
      abort     = 0;
      out_ready = 0;
      #3;
      rst_N = 1'b0;
      #1;
      check_reset_values();
      m_mode = 0;
      m_vld  = 0;
      m_idx  = 0;
      @(posedge clk);
      #1;
      rst_N = 1'b1;
      cyc++;
   endtask

   initial begin
      seed    = $urandom;
      m_mode  = 0;
      m_prog  = 0;
      m_idx   = 0;
      m_vld   = 0;
      m_first = 1;
      @(posedge clk);
      #1;
      check_reset_values();
      rst_N = 1'b1;
      clear_stats();

`ifndef RES_SEQ_LOOP_EN
      // Basic run with the consumer always ready.
      clear_stats();
      cycle(1, 0, 1);
      chk("clear_at_1", state_clr_N, 0);
      run_until(s, 22, 1);
      chk("first_beat_valid", out_valid, 1);
      chk("first_beat_idx", out_idx, 4);
      run_until(s, 70, 1);
      chk("basic_done_cycle", done_cyc - s, 67);
      chk("basic_beats", n_beats, 12);
      chk("basic_done_count", n_done, 1);

      // Backpressure for 10 cycles from the first beat.
      clear_stats();
      cycle(1, 0, 1);
      run_until(s, 22, 1);
      run_until(s, 30, 0);
      chk("bp_rom_addr_frozen", rom_addr, 5);
      chk("bp_pe_ce_low", pe_ce, 0);
      chk("bp_data_held", out_data, pattern(ADDR_W'(4), seed));
      run_until(s, 32, 0);
      run_until(s, 80, 1);
      chk("bp_done_cycle", done_cyc - s, 74);
      chk("bp_beats", n_beats, 12);

      // Abort at cycle 30, restart at 40.
      clear_stats();
      cycle(1, 0, 1);
      run_until(s, 30, 1);
      cycle(0, 1, 1);
      chk("abort_busy", busy, 0);
      chk("abort_valid", out_valid, 0);
      run_until(s, 40, 1);
      chk("abort_no_done", n_done, 0);
      cycle(1, 0, 1);
      run_until(s, 62, 1);
      chk("restart_valid", out_valid, 1);
      chk("restart_idx", out_idx, 4);
      run_until(s, 110, 1);
      chk("restart_done_count", n_done, 1);

      // Stray start pulses during a run are ignored.
      clear_stats();
      cycle(1, 0, 1);
      run_until(s, 5, 1);
      cycle(1, 0, 1);
      run_until(s, 20, 1);
      cycle(1, 0, 1);
      run_until(s, 90, 1);
      chk("stray_done_cycle", done_cyc - s, 67);
      chk("stray_done_count", n_done, 1);
      chk("stray_beats", n_beats, 12);

      // Asynchronous reset in the middle of a run.
      clear_stats();
      cycle(1, 0, 1);
      run_until(s, 25, 1);
      do_reset();
      cycle(0, 0, 1);
`else
      // Continuous mode: second pass follows immediately without CLEAR or done.
      clear_stats();
      cycle(1, 0, 1);
      run_until(s, 66, 1);
      chk("loop_last_idx", out_idx, 15);
      run_until(s, 70, 1);
      chk("loop_wrap_valid", out_valid, 1);
      chk("loop_wrap_idx", out_idx, 0);
      run_until(s, 140, 1);
      chk("loop_no_done", n_done, 0);
      cycle(0, 1, 1);
`endif

      // Random traffic: occasional starts/aborts, random consumer readiness.
      for (int i = 0; i < 2500; i++) begin
         cycle($urandom_range(0, 29) == 0, $urandom_range(0, 399) == 0,
               $urandom_range(0, 99) < 60);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/res_seq_ctrl.md
# res_seq_ctrl

Run sequencer for the ESN reservoir datapath: the 8-neuron, two-PE array fed by the input sample ROM and a registered state-feedback bus. On a start request it clears the feedback state, steps the input-ROM address once per reservoir update, and gates the PE clock-enable so that each sample completes the full recurrence before the next one is issued. It drops the first WASHOUT states and delivers the remaining 128-bit state vectors over a valid/ready stream, stalling the reservoir under backpressure. It sits between the reservoir top level and the readout/capture logic.

## Interface
Parameters:
- ADDR_W, 6, input ROM address width
- NUM_SAMPLES, 64, samples per run (2..2^ADDR_W)
- WASHOUT, 8, leading states discarded (0..NUM_SAMPLES-1)
- STEP_CYC, 4, cycles per reservoir update (ROM read + PE pipeline + feedback register); ≥2
- XW, 128, state vector width (8×16)

Ports:
- clk  in  1  the single clock; all logic is clocked on its rising edge
- rst_N  in  1  reset, asynchronous and active-low
- start  in  1  one-cycle run request
- abort  in  1  cancels the run
- busy  out  1  run in progress (CLEAR/RUN/DRAIN)
- done  out  1  one-cycle pulse when a run completes normally
- rom_addr  out  ADDR_W  input ROM address
- pe_ce  out  1  clock enable to both PEs
- state_clr_N  out  1  active-low clear to the feedback registers
- xstate_in  in  XW  reservoir state from the PEs
- out_data  out  XW  captured state
- out_idx  out  ADDR_W  sample index of out_data
- out_valid  out  1  out_data/out_idx valid
- out_ready  in  1  consumer accepts the beat

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: busy=0, pe_ce=0. start=1 moves to CLEAR. start is ignored in every other state.
- CLEAR: lasts 1 cycle. state_clr_N=0, rom_addr=0, sample counter n=0, phase=0. Then RUN.
- RUN:
  - rom_addr=n, held for the whole step.
  - phase counts 0..STEP_CYC-1, and pe_ce=1 while it advances.
  - At phase STEP_CYC-1, the capture edge:
    - if n≥WASHOUT, xstate_in is registered into out_data, out_idx=n and out_valid=1;
    - then n increments and phase returns to 0.
  - After the capture with n=NUM_SAMPLES-1, go to DRAIN.
- Stall: if a capture is due (n≥WASHOUT, phase=STEP_CYC-1) while out_valid=1 and out_ready=0, phase holds, pe_ce=0 and rom_addr holds. Capture occurs on the cycle the pending beat is accepted.
- Handshake:
  - A beat transfers on the edge where out_valid=1 and out_ready=1.
  - out_data and out_idx stay stable while out_valid=1.
  - A capture on the same edge as an acceptance reloads the register, so out_valid stays 1.
- DRAIN: pe_ce=0. Wait until the last beat is accepted (immediately if WASHOUT covers all samples), then DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- abort=1 in any state: next state IDLE, out_valid cleared, pe_ce=0, no done pulse. abort takes priority over start and over capture.
- Arithmetic: n is an ADDR_W-bit counter and the phase counter is $clog2(STEP_CYC) bits. NUM_SAMPLES=2^ADDR_W wraps n to 0 only under loop mode.

## Timing
- Reset values: busy=0, done=0, rom_addr=0, pe_ce=0, state_clr_N=1, out_data=0, out_idx=0, out_valid=0, state=IDLE.
- All outputs are registered except pe_ce. pe_ce is combinational from state, phase, out_valid and out_ready.
- Start is sampled at edge k:
  - CLEAR occupies cycle k+1;
  - RUN starts at k+2;
  - the capture of sample n is visible (out_valid) at cycle k+2+STEP_CYC·(n+1).
- Unstalled run length from start to done is 2+STEP_CYC·NUM_SAMPLES+1 cycles.
- Reset asserted mid-run returns to IDLE immediately. No done pulse is issued.

## Configuration
- RES_SEQ_LOOP_EN defined: continuous mode.
  - After the n=NUM_SAMPLES-1 capture, RUN continues with n=0 and rom_addr=0. There is no CLEAR, so reservoir state carries over.
  - Washout applies only on the first pass.
  - The run ends only by abort; done is never pulsed.
- RES_SEQ_LOOP_EN undefined: single-shot behaviour as described above.

## Test plan
Bench settings: NUM_SAMPLES=16, WASHOUT=4, STEP_CYC=4.
- Basic run: out_ready=1, start at cycle 0.
  - state_clr_N=0 at cycle 1.
  - First beat at cycle 22 with out_idx=4; 12 beats in total, idx 4..15.
  - done at cycle 67; busy high for cycles 1..66.
- Backpressure: out_ready=0 for 10 cycles from the first beat.
  - pe_ce=0 and rom_addr frozen at 5 until acceptance.
  - out_data stays unchanged; no beat is lost or duplicated.
  - done is delayed by exactly the stall length.
- Abort at cycle 30: IDLE at cycle 31, out_valid=0, no done. A new start at cycle 40 reruns from CLEAR with idx starting at 4.
- start pulses at cycles 5 and 20 during a run are ignored: only one run, and one done.
- Reset (rst_N low) at cycle 25 of a run: all outputs at reset values asynchronously, without waiting for a clock edge.
- RES_SEQ_LOOP_EN: after idx 15, the next beat is idx 0 at +4 cycles, with no CLEAR and no done.
